// File: rtl/bit_serial_alu_ctrl.sv
// bit_serial_alu_ctrl
// Sequencer that computes a WIDTH-bit AND/OR/ADD/SUB/SLT/NOR one bit per cycle,
// LSB first, through an external 1-bit ALU slice. Carry is kept in a register
// between slice evaluations.
// Optional feature: define ALU_CTRL_SAT_EN to saturate ADD/SUB results on
// signed overflow instead of wrapping.
module bit_serial_alu_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       func,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] y,
   output logic             overflow,
   output logic             alu_a,
   output logic             alu_b,
   output logic             alu_sm,
   output logic             alu_sa,
   output logic             alu_sb,
   output logic             alu_cin,
   output logic [1:0]       alu_op,
   input  logic             alu_result,
   input  logic             alu_set,
   input  logic             alu_ovf
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   localparam logic [2:0] F_AND = 3'b000;
   localparam logic [2:0] F_OR  = 3'b001;
   localparam logic [2:0] F_ADD = 3'b010;
   localparam logic [2:0] F_SUB = 3'b011;
   localparam logic [2:0] F_SLT = 3'b100;
   localparam logic [2:0] F_NOR = 3'b101;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_reg;
   logic [CW-1:0]    cnt_reg;
   logic             carry_reg;
   logic [2:0]       func_reg;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic [WIDTH-1:0] res_reg;
   logic [WIDTH-1:0] y_reg;
   logic             ovf_reg;
   logic             ready_reg;
   logic             busy_reg;
   logic             done_reg;

   logic [1:0]       op_next;
   logic             sa_next;
   logic             sb_next;
   logic             cin_next;
   logic             arith;
   logic             last_bit;
   logic             run;
   logic [WIDTH-1:0] y_next;

   assign run      = (state_reg == RUN);
   assign last_bit = (cnt_reg == LAST);
   assign arith    = (func_reg == F_ADD) || (func_reg == F_SUB);

   // Slice control decode from the latched function; carry-in seeds subtraction
   always_comb begin
      op_next = 2'b00;
      sa_next = 1'b0;
      sb_next = 1'b0;
      case (func_reg)
         F_AND: op_next = 2'b00;
         F_OR:  op_next = 2'b01;
         F_ADD: op_next = 2'b10;
         F_SUB: begin op_next = 2'b10; sb_next = 1'b1; end
         F_SLT: begin op_next = 2'b11; sb_next = 1'b1; end
         F_NOR: begin op_next = 2'b00; sa_next = 1'b1; sb_next = 1'b1; end
         default: op_next = 2'b00;
      endcase
      if (cnt_reg == '0)
         cin_next = (func_reg == F_SUB) || (func_reg == F_SLT);
      else
         cin_next = carry_reg;
   end

   // Slice drive is only active while running; quiet zeros otherwise
   assign alu_a   = run & a_reg[cnt_reg];
   assign alu_b   = run & b_reg[cnt_reg];
   assign alu_sm  = 1'b0;
   assign alu_sa  = run & sa_next;
   assign alu_sb  = run & sb_next;
   assign alu_cin = run & cin_next;
   assign alu_op  = run ? op_next : 2'b00;

   // Final result assembled during the last bit, including the bit just produced
   always_comb begin
      y_next = res_reg | ({{(WIDTH-1){1'b0}}, alu_result} << (WIDTH - 1));
      if (func_reg == F_SLT)
         y_next = {{(WIDTH-1){1'b0}}, alu_set};
`ifdef ALU_CTRL_SAT_EN
      if (arith && alu_ovf)
         y_next = a_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                 : {1'b0, {(WIDTH-1){1'b1}}};
`endif
   end

   // Control FSM with registered handshake outputs and result capture
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         carry_reg <= 1'b0;
         func_reg  <= 3'b000;
         a_reg     <= '0;
         b_reg     <= '0;
         res_reg   <= '0;
         y_reg     <= '0;
         ovf_reg   <= 1'b0;
         ready_reg <= 1'b1;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               done_reg <= 1'b0;
               if (start) begin
                  func_reg  <= func;
                  a_reg     <= op_a;
                  b_reg     <= op_b;
                  res_reg   <= '0;
                  cnt_reg   <= '0;
                  carry_reg <= 1'b0;
                  ready_reg <= 1'b0;
                  if (func <= F_NOR) begin
                     state_reg <= RUN;
                     busy_reg  <= 1'b1;
                  end else begin
                     state_reg <= DONE;
                     done_reg  <= 1'b1;
                     y_reg     <= '0;
                     ovf_reg   <= 1'b0;
                  end
               end
            end
            RUN: begin
               res_reg[cnt_reg] <= alu_result;
               carry_reg        <= cin_next ^ alu_ovf;
               cnt_reg          <= cnt_reg + CW'(1);
               if (last_bit) begin
                  state_reg <= DONE;
                  cnt_reg   <= '0;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  y_reg     <= y_next;
                  ovf_reg   <= arith & alu_ovf;
               end
            end
            DONE: begin
               state_reg <= IDLE;
               done_reg  <= 1'b0;
               ready_reg <= 1'b1;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign ready    = ready_reg;
   assign busy     = busy_reg;
   assign done     = done_reg;
   assign y        = y_reg;
   assign overflow = ovf_reg;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// tb_bit_serial_alu_ctrl
// Drives bit_serial_alu_ctrl (WIDTH=8) with directed and random operations,
// models the 1-bit ALU slice, and compares results against word-level arithmetic.
module tb_bit_serial_alu_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [2:0]   func = 3'b000;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         ready, busy, done, overflow;
   logic [W-1:0] y;
   logic         alu_a, alu_b, alu_sm, alu_sa, alu_sb, alu_cin;
   logic [1:0]   alu_op;
   logic         alu_result, alu_set, alu_ovf;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bit_serial_alu_ctrl #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .func(func), .op_a(op_a), .op_b(op_b),
      .ready(ready), .busy(busy), .done(done), .y(y), .overflow(overflow),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sm(alu_sm), .alu_sa(alu_sa), .alu_sb(alu_sb),
      .alu_cin(alu_cin), .alu_op(alu_op),
      .alu_result(alu_result), .alu_set(alu_set), .alu_ovf(alu_ovf)
   );

   // 1-bit ALU slice: optional inversion, full adder, op mux; set is the corrected sign
   logic ai, bi, sum_b, cout_b;
   always_comb begin
      ai     = alu_a ^ alu_sa;
      bi     = alu_b ^ alu_sb;
      sum_b  = ai ^ bi ^ alu_cin;
      cout_b = (ai & bi) | (ai & alu_cin) | (bi & alu_cin);
      alu_ovf = alu_cin ^ cout_b;
      alu_set = sum_b ^ alu_ovf;
      case (alu_op)
         2'b00:   alu_result = ai & bi;
         2'b01:   alu_result = ai | bi;
         2'b10:   alu_result = sum_b;
         default: alu_result = alu_sm;
      endcase
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Word-level reference: returns {overflow, y}
   function automatic logic [W:0] ref_model(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      int sa, sb, s;
      logic [W-1:0] r;
      logic         v;
      sa = $signed(a);
      sb = $signed(b);
      r = '0;
      v = 1'b0;
      case (f)
         3'd0: r = a & b;
         3'd1: r = a | b;
         3'd2: begin s = sa + sb; r = W'(s); v = (s > 127) || (s < -128); end
         3'd3: begin s = sa - sb; r = W'(s); v = (s > 127) || (s < -128); end
         3'd4: r = (sa < sb) ? 8'd1 : 8'd0;
         3'd5: r = ~(a | b);
         default: r = '0;
      endcase
`ifdef ALU_CTRL_SAT_EN
      if (v) r = a[W-1] ? 8'h80 : 8'h7F;
`endif
      return {v, r};
   endfunction

   // One transaction; entered and left at #1 after a rising edge with ready=1
   task automatic do_op(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit hold_start);
      logic [W:0] exp;
      int         n;
      int         exp_lat;
      exp     = ref_model(f, a, b);
      exp_lat = (f <= 3'd5) ? W : 0;
      check_val("ready_before", ready, 1);
      start = 1'b1; func = f; op_a = a; op_b = b;
      @(posedge clk); #1;
      // scramble inputs after acceptance: must not disturb the operation
      op_a = W'($urandom); op_b = W'($urandom); func = 3'($urandom_range(0, 5));
      start = hold_start;
      check_val("busy_after_accept", busy, (f <= 3'd5) ? 1 : 0);
      check_val("ready_after_accept", ready, 0);
      n = 0;
      while (!done && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check_val("done_latency", n, exp_lat);
      check_val("y", y, exp[W-1:0]);
      check_val("overflow", overflow, exp[W]);
      @(posedge clk); #1;
      check_val("done_pulse_end", done, 0);
      check_val("ready_back", ready, 1);
      check_val("y_held", y, exp[W-1:0]);
      check_val("alu_idle_zero", {alu_a, alu_b, alu_sm, alu_sa, alu_sb, alu_cin, alu_op}, 0);
      start = 1'b0;
      $display("op f=%0d a=0x%02h b=0x%02h -> y=0x%02h ovf=%0d lat=%0d hold=%0d",
               f, a, b, y, overflow, n, hold_start);
   endtask

   initial begin
      int seen_done;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_val("rst_ready", ready, 1);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_y", y, 0);
      check_val("rst_ovf", overflow, 0);
      check_val("rst_alu_zero", {alu_a, alu_b, alu_sm, alu_sa, alu_sb, alu_cin, alu_op}, 0);

      // directed cases
      do_op(3'd2, 8'h05, 8'h03, 0);
      do_op(3'd3, 8'h03, 8'h05, 0);
      do_op(3'd2, 8'h7F, 8'h01, 0);
      do_op(3'd4, 8'hFD, 8'h02, 0);
      do_op(3'd4, 8'h02, 8'hFD, 0);
      do_op(3'd5, 8'hF0, 8'h0F, 0);
      do_op(3'd0, 8'hCA, 8'h6F, 0);
      do_op(3'd1, 8'h81, 8'h18, 0);
      do_op(3'd3, 8'h80, 8'h01, 0);
      do_op(3'd2, 8'hFF, 8'h01, 1);
      do_op(3'd7, 8'h12, 8'h34, 0);
      do_op(3'd6, 8'hFF, 8'hFF, 0);

      // reset in the middle of an ADD (bit 4)
      start = 1'b1; func = 3'd2; op_a = 8'h11; op_b = 8'h22;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check_val("midrst_done", done, 0);
      check_val("midrst_y", y, 0);
      check_val("midrst_ready", ready, 1);
      check_val("midrst_busy", busy, 0);
      seen_done = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) seen_done = 1;
      end
      check_val("midrst_no_done", seen_done, 0);
      do_op(3'd2, 8'h21, 8'h13, 0);

      // reset wins over a simultaneous start
      rst = 1'b1; start = 1'b1; func = 3'd2; op_a = 8'h01; op_b = 8'h01;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      check_val("rst_prio_busy", busy, 0);
      check_val("rst_prio_ready", ready, 1);
      @(posedge clk); #1;
      check_val("rst_prio_idle", busy, 0);

      // random operations, occasionally illegal, occasionally holding start
      for (int k = 0; k < 40; k++) begin
         logic [2:0] rf;
         rf = (($urandom % 8) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
         do_op(rf, W'($urandom), W'($urandom), ($urandom % 4) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/bit_serial_alu_ctrl.md
BIT_SERIAL_ALU_CTRL -- requirements
Module: bit_serial_alu_ctrl

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (legal range 2..64).
REQ-002 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  reset, synchronous and active-high.
REQ-004 Port: start  in  1  request; accepted only when ready=1.
REQ-005 Port: func  in  3  000 AND, 001 OR, 010 ADD, 011 SUB, 100 SLT, 101 NOR, 110/111 illegal.
REQ-006 Port: op_a, op_b  in  WIDTH  operands, two's complement for ADD/SUB/SLT.
REQ-007 Port: ready  out  1  high only in IDLE.
REQ-008 Port: busy  out  1  high in RUN.
REQ-009 Port: done  out  1  one-cycle pulse in DONE.
REQ-010 Port: y  out  WIDTH  result, held stable from DONE until the next accepted start.
REQ-011 Port: overflow  out  1  signed overflow of ADD/SUB, else 0; held with y.
REQ-012 Port: alu_a, alu_b, alu_sm, alu_sa, alu_sb, alu_cin  out  1 each  drive to the external 1-bit ALU slice.
REQ-013 Port: alu_op  out  2  slice op select (00 AND, 01 OR, 10 sum, 11 pass sm).
REQ-014 Port: alu_result, alu_set, alu_ovf  in  1 each  combinational slice outputs (alu_ovf = cin XOR cout).

Function
REQ-015 FSM states IDLE, RUN, DONE; IDLE->RUN on start&ready; RUN->DONE after bit WIDTH-1; DONE->IDLE unconditionally.
REQ-016 On acceptance, op_a, op_b and func are latched; later changes on those inputs are ignored until the next acceptance.
REQ-017 RUN lasts exactly WIDTH cycles; bit counter i = 0..WIDTH-1, LSB first; alu_a/alu_b = latched bit i.
REQ-018 Latency: start accepted at edge t -> done high in cycle t+WIDTH+1 -> ready high in cycle t+WIDTH+2; no back-to-back overlap.
REQ-019 Slice controls per func: AND op=00 sa=0 sb=0; OR op=01 sa=0 sb=0; NOR op=00 sa=1 sb=1; ADD op=10 sa=0 sb=0; SUB op=10 sa=0 sb=1; SLT op=11 sa=0 sb=1 sm=0.
REQ-020 alu_cin = 1 at i=0 for SUB/SLT, 0 at i=0 otherwise; for i>0 alu_cin = registered carry.
REQ-021 Carry register next value = alu_cin XOR alu_ovf, captured every RUN cycle.
REQ-022 AND/OR/NOR/ADD/SUB: alu_result sampled each RUN cycle into bit i of the result shift register.
REQ-023 SLT: result bits discarded; alu_set captured at i=WIDTH-1; y = {WIDTH-1 zeros, captured set}.
REQ-024 overflow = alu_ovf sampled at i=WIDTH-1 for ADD/SUB; 0 for all other funcs.
REQ-025 Illegal func: no RUN; IDLE->DONE directly; y=0, overflow=0; done one cycle after acceptance.
REQ-026 start while busy or in DONE is ignored, with no effect on the operation in flight.
REQ-027 Outside RUN all alu_* outputs are driven 0.

Reset
REQ-028 rst=1 at any edge forces IDLE, counter=0, carry=0, y=0, overflow=0, done=0, busy=0, ready=1 on the following cycle.
REQ-029 rst mid-RUN aborts the operation with no done pulse; rst takes priority over a simultaneous start.

Configuration
REQ-030 Macro ALU_CTRL_SAT_EN defined: ADD/SUB with overflow=1 set y to 0111...1 if latched op_a MSB=0, else 1000...0; overflow still reports 1.
REQ-031 Macro ALU_CTRL_SAT_EN undefined: ADD/SUB results wrap modulo 2^WIDTH; no saturation logic present.

Verification (WIDTH=8, slice model attached)
REQ-032 ADD 0x05+0x03, start at edge t -> y=0x08, overflow=0, done exactly in cycle t+9, ready back in cycle t+10.
REQ-033 SUB 0x03-0x05 -> y=0xFE, overflow=0; ADD 0x7F+0x01 -> y=0x80, overflow=1 (y=0x7F with ALU_CTRL_SAT_EN).
REQ-034 SLT 0xFD vs 0x02 -> y=0x01; SLT 0x02 vs 0xFD -> y=0x00; NOR 0xF0,0x0F -> y=0x00.
REQ-035 rst pulsed at i=4 of an ADD -> no done pulse, y=0, ready=1 on the next cycle; a new ADD then completes correctly.
REQ-036 start held high during RUN with different operands -> first result unaffected, no second operation until ready=1; func=111 -> done after 1 cycle with y=0.
